// File: rtl/dds_cmd_pkg.sv
// Shared constants and types for the DDS command framer: header byte, opcodes,
// rejection codes and the receive FSM state encoding.
package dds_cmd_pkg;

  localparam logic [7:0] HDR       = 8'hA5;

  localparam logic [7:0] OPC_WAVE  = 8'h01;
  localparam logic [7:0] OPC_FREQ  = 8'h02;
  localparam logic [7:0] OPC_AMP   = 8'h03;
  localparam logic [7:0] OPC_PHASE = 8'h04;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_OPC   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPC  = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CSUM = 3'd4
  } rx_state_t;

  function automatic logic is_valid_opc(input logic [7:0] opc);
    return (opc >= OPC_WAVE) && (opc <= OPC_PHASE);
  endfunction

endpackage

// File: rtl/cmd_frame_rx_if.sv
// Byte stream from the FT245 receive side: a one-cycle valid strobe with its data byte.
interface cmd_frame_rx_if;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (output byte_valid, output byte_data);
  modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/cmd_frame_rx_gap_timer.sv
// Saturating inter-byte gap counter; expired stays high once the limit is reached
// until the next clear.
module gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/cmd_frame_rx.sv
// Assembles A5/OPC/DHI/DLO/CS frames from the byte stream and commits the
// signal-generator parameter selected by the opcode when the XOR checksum matches.
module cmd_frame_rx
  import dds_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  cmd_frame_rx_if.slave       rx,
  output logic [2:0]          state,
  output logic [11:0]         state_freq,
  output logic [3:0]          state_amp,
  output logic [7:0]          state_phase,
  output logic                param_update,
  output logic                frame_err,
  output logic [1:0]          err_code
);

  rx_state_t  cur_st, nxt_st;
  logic [7:0] opc_q, dhi_q, dlo_q;
  logic       expired;
  logic       commit;
  logic       err;
  logic [1:0] err_nxt;

  gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx.byte_valid),
    .enable  (cur_st != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // A byte always takes priority over a timeout landing in the same cycle.
  always_comb begin
    nxt_st  = cur_st;
    commit  = 1'b0;
    err     = 1'b0;
    err_nxt = ERR_NONE;
    if (rx.byte_valid) begin
      unique case (cur_st)
        ST_IDLE: if (rx.byte_data == HDR) nxt_st = ST_OPC;
        ST_OPC:  nxt_st = ST_DHI;
        ST_DHI:  nxt_st = ST_DLO;
        ST_DLO:  nxt_st = ST_CSUM;
        ST_CSUM: begin
          nxt_st = ST_IDLE;
          if (rx.byte_data != (opc_q ^ dhi_q ^ dlo_q)) begin
            err     = 1'b1;
            err_nxt = ERR_CSUM;
          end else if (!is_valid_opc(opc_q)) begin
            err     = 1'b1;
            err_nxt = ERR_OPC;
          end else begin
            commit  = 1'b1;
          end
        end
        default: nxt_st = ST_IDLE;
      endcase
    end else if ((cur_st != ST_IDLE) && expired) begin
      nxt_st  = ST_IDLE;
      err     = 1'b1;
      err_nxt = ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= '0;
      dhi_q <= '0;
      dlo_q <= '0;
    end else if (rx.byte_valid) begin
      unique case (cur_st)
        ST_OPC:  opc_q <= rx.byte_data;
        ST_DHI:  dhi_q <= rx.byte_data;
        ST_DLO:  dlo_q <= rx.byte_data;
        default: ;
      endcase
    end
  end

  // Parameter registers reset to a safe audible default: sine-0, lowest freq, full amplitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= 3'd0;
      state_freq   <= 12'd1;
      state_amp    <= 4'hF;
      state_phase  <= 8'd0;
      param_update <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      param_update <= commit;
      frame_err    <= err;
      if (err) err_code <= err_nxt;
      if (commit) begin
        unique case (opc_q)
          OPC_WAVE:  state       <= dlo_q[2:0];
          OPC_FREQ:  state_freq  <= {dhi_q[3:0], dlo_q};
          OPC_AMP:   state_amp   <= dlo_q[3:0];
          OPC_PHASE: state_phase <= dlo_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed plus randomized bench for cmd_frame_rx against a frame-level reference model.
module tb_cmd_frame_rx;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic [2:0]  state;
  logic [11:0] state_freq;
  logic [3:0]  state_amp;
  logic [7:0]  state_phase;
  logic        param_update;
  logic        frame_err;
  logic [1:0]  err_code;

  int compared   = 0;
  int mismatched = 0;

  cmd_frame_rx_if bus ();

  cmd_frame_rx #(.TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (bus),
    .state        (state),
    .state_freq   (state_freq),
    .state_amp    (state_amp),
    .state_phase  (state_phase),
    .param_update (param_update),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: holds the bytes of the frame in progress and the current idle run length.
  logic [2:0]  m_state;
  logic [11:0] m_freq;
  logic [3:0]  m_amp;
  logic [7:0]  m_phase;
  logic        m_pu;
  logic        m_fe;
  logic [1:0]  m_code;
  logic [7:0]  frame_q[$];
  int          idle_run;

  task automatic model_reset();
    m_state = 3'd0;
    m_freq  = 12'd1;
    m_amp   = 4'hF;
    m_phase = 8'd0;
    m_pu    = 1'b0;
    m_fe    = 1'b0;
    m_code  = 2'd0;
    frame_q.delete();
    idle_run = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    logic [7:0] opc, dhi, dlo, cs;
    m_pu = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      idle_run = 0;
      if (frame_q.size() == 0) begin
        if (d == 8'hA5) frame_q.push_back(d);
      end else begin
        frame_q.push_back(d);
        if (frame_q.size() == 5) begin
          opc = frame_q[1];
          dhi = frame_q[2];
          dlo = frame_q[3];
          cs  = frame_q[4];
          if (cs != (opc ^ dhi ^ dlo)) begin
            m_fe = 1'b1; m_code = 2'd1;
          end else if (opc < 8'd1 || opc > 8'd4) begin
            m_fe = 1'b1; m_code = 2'd2;
          end else begin
            m_pu = 1'b1;
            case (opc)
              8'd1: m_state = dlo[2:0];
              8'd2: m_freq  = {dhi[3:0], dlo};
              8'd3: m_amp   = dlo[3:0];
              default: m_phase = dlo;
            endcase
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() > 0) begin
      idle_run++;
      if (idle_run > TMO) begin
        m_fe = 1'b1; m_code = 2'd3;
        frame_q.delete();
        idle_run = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".state"},        32'(state),        32'(m_state));
    check({tag, ".state_freq"},   32'(state_freq),   32'(m_freq));
    check({tag, ".state_amp"},    32'(state_amp),    32'(m_amp));
    check({tag, ".state_phase"},  32'(state_phase),  32'(m_phase));
    check({tag, ".param_update"}, 32'(param_update), 32'(m_pu));
    check({tag, ".frame_err"},    32'(frame_err),    32'(m_fe));
    check({tag, ".err_code"},     32'(err_code),     32'(m_code));
    check({tag, ".exclusive"},    32'(param_update & frame_err), 32'd0);
  endtask

  // Drive on the falling edge, let the model see the rising edge, then compare just after it.
  task automatic apply_stimulus(input string tag, input bit v, input logic [7:0] d);
    @(negedge clk);
    bus.byte_valid = v;
    bus.byte_data  = v ? d : 8'($urandom);
    @(posedge clk);
    model_step(v, d);
    #1;
    check_output(tag);
  endtask

  task automatic send5(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    apply_stimulus(tag, 1'b1, b0);
    apply_stimulus(tag, 1'b1, b1);
    apply_stimulus(tag, 1'b1, b2);
    apply_stimulus(tag, 1'b1, b3);
    apply_stimulus(tag, 1'b1, b4);
  endtask

  initial begin
    logic [7:0] opc, dhi, dlo, cs;
    rst_n          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) apply_stimulus("idle", 1'b0, 8'h00);

    send5("freq", 8'hA5, 8'h02, 8'h0A, 8'hBC, 8'hB4);
    check("freq_const", 32'(state_freq), 32'h0ABC);
    check("freq_pulse", 32'(param_update), 32'd1);
    apply_stimulus("freq_after", 1'b0, 8'h00);
    check("freq_single_pulse", 32'(param_update), 32'd0);

    send5("phase", 8'hA5, 8'h04, 8'h00, 8'h5A, 8'h5E);
    check("phase_const", 32'(state_phase), 32'h5A);

    apply_stimulus("garbage", 1'b1, 8'h00);
    apply_stimulus("garbage", 1'b1, 8'hFF);
    send5("bad_cs", 8'hA5, 8'h03, 8'h00, 8'h07, 8'h00);
    check("bad_cs_err", 32'(frame_err), 32'd1);
    check("bad_cs_code", 32'(err_code), 32'd1);
    check("bad_cs_amp", 32'(state_amp), 32'hF);
    send5("amp", 8'hA5, 8'h03, 8'h00, 8'h07, 8'h04);
    check("amp_const", 32'(state_amp), 32'h7);

    send5("bad_opc", 8'hA5, 8'h09, 8'h00, 8'h01, 8'h08);
    check("bad_opc_err", 32'(frame_err), 32'd1);
    check("bad_opc_code", 32'(err_code), 32'd2);
    check("bad_opc_upd", 32'(param_update), 32'd0);

    apply_stimulus("tmo", 1'b1, 8'hA5);
    apply_stimulus("tmo", 1'b1, 8'h01);
    repeat (TMO) apply_stimulus("tmo_gap", 1'b0, 8'h00);
    apply_stimulus("tmo_fire", 1'b0, 8'h00);
    check("tmo_err", 32'(frame_err), 32'd1);
    check("tmo_code", 32'(err_code), 32'd3);
    send5("wave", 8'hA5, 8'h01, 8'h00, 8'h03, 8'h02);
    check("wave_const", 32'(state), 32'd3);

    apply_stimulus("tmo_edge", 1'b1, 8'hA5);
    apply_stimulus("tmo_edge", 1'b1, 8'h01);
    repeat (TMO) apply_stimulus("tmo_edge_gap", 1'b0, 8'h00);
    apply_stimulus("tmo_edge_byte", 1'b1, 8'h00);
    check("tmo_edge_noerr", 32'(frame_err), 32'd0);
    apply_stimulus("tmo_edge", 1'b1, 8'h05);
    apply_stimulus("tmo_edge", 1'b1, 8'h04);
    check("tmo_edge_wave", 32'(state), 32'd5);

    apply_stimulus("rst_mid", 1'b1, 8'hA5);
    apply_stimulus("rst_mid", 1'b1, 8'h02);
    apply_stimulus("rst_mid", 1'b1, 8'h0A);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("rst_async");
    @(negedge clk);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("rst_tail", 1'b1, 8'hBC);
    apply_stimulus("rst_tail", 1'b1, 8'hB4);
    check("rst_tail_upd", 32'(param_update), 32'd0);
    check("rst_tail_err", 32'(frame_err), 32'd0);
    check("rst_tail_freq", 32'(state_freq), 32'd1);

    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 9) == 0) apply_stimulus("rnd_junk", 1'b1, 8'($urandom));
      opc = 8'($urandom_range(0, 5));
      dhi = 8'($urandom);
      dlo = 8'($urandom);
      cs  = opc ^ dhi ^ dlo;
      if ($urandom_range(0, 4) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      for (int k = 0; k < 5; k++) begin
        int gap;
        gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 2, TMO + 2))
                                           : int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) apply_stimulus("rnd_gap", 1'b0, 8'h00);
        case (k)
          0: apply_stimulus("rnd", 1'b1, 8'hA5);
          1: apply_stimulus("rnd", 1'b1, opc);
          2: apply_stimulus("rnd", 1'b1, dhi);
          3: apply_stimulus("rnd", 1'b1, dlo);
          default: apply_stimulus("rnd", 1'b1, cs);
        endcase
      end
    end
    repeat (TMO + 3) apply_stimulus("drain", 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
